regfile_writeback_ctrl: RTL and testbench

//  Write-side controller for the integer register file. Merges ALU and load results into one rd write port.

---
 rtl/regfile_wb_if.sv | 35 +++
 rtl/regfile_writeback_ctrl.sv | 109 ++++++++++
 tb/tb_regfile_writeback_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// regfile_wb_if: issue, hazard-query, result and register-file write signals of the writeback controller
interface regfile_wb_if #(
    parameter int XLEN  = 32,
    parameter int XADDR = 5
);
    logic             issue_valid;
    logic [XADDR-1:0] issue_rd;
    logic             issue_ready;
    logic [XADDR-1:0] rs1_addr;
    logic [XADDR-1:0] rs2_addr;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             alu_valid;
    logic             alu_ready;
    logic [XADDR-1:0] alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             ld_valid;
    logic [XADDR-1:0] ld_rd;
    logic [XLEN-1:0]  ld_data;
    logic             wr_en;
    logic [XADDR-1:0] rd_addr;
    logic [XLEN-1:0]  rd_data;

    modport master (
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  issue_ready, rs1_busy, rs2_busy, alu_ready, wr_en, rd_addr, rd_data
    );

    modport slave (
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output issue_ready, rs1_busy, rs2_busy, alu_ready, wr_en, rd_addr, rd_data
    );
endinterface

// File: rtl/regfile_writeback_ctrl.sv
// regfile_writeback_ctrl: merges load and buffered ALU results into one register-file write port and
// keeps a per-register pending-write scoreboard; define WB_FORWARD_EN to drop busy in the final write cycle
module regfile_writeback_ctrl #(
    parameter int XLEN       = 32,
    parameter int XADDR      = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 2
) (
    input logic        clk_i,
    input logic        rst_i,
    regfile_wb_if.slave bus
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int NREG = 1 << XADDR;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [XADDR-1:0] rd;
        logic [XLEN-1:0]  data;
    } entry_t;

    entry_t           fifo_q [FIFO_DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [PW:0]      count_q, count_d;
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             wr_en_q, wr_en_d;
    logic [XADDR-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]  rd_data_q, rd_data_d;
    logic             full, empty, alu_acc, push, pop, sel_valid, issue_ready, issue_acc;
    entry_t           sel;

    // Loads win the port; otherwise the FIFO head drains, and an ALU result skips the empty FIFO
    always_comb begin
        full      = count_q == (PW+1)'(FIFO_DEPTH);
        empty     = count_q == '0;
        alu_acc   = bus.alu_valid && !full;
        pop       = !bus.ld_valid && !empty;
        push      = alu_acc && (bus.ld_valid || !empty);
        sel_valid = bus.ld_valid || !empty || alu_acc;
        sel       = bus.ld_valid ? entry_t'({bus.ld_rd, bus.ld_data}) :
                    !empty       ? fifo_q[head_q] :
                                   entry_t'({bus.alu_rd, bus.alu_data});
        wr_en_d   = sel_valid && sel.rd != '0;
        rd_addr_d = wr_en_d ? sel.rd : rd_addr_q;
        rd_data_d = wr_en_d ? sel.data : rd_data_q;
        count_d   = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    // A saturated counter still accepts an issue when that register retires in the same cycle
    always_comb begin
        issue_ready = bus.issue_rd == '0 || cnt_q[bus.issue_rd] != CNT_MAX ||
                      (wr_en_q && rd_addr_q == bus.issue_rd);
        issue_acc   = bus.issue_valid && issue_ready && bus.issue_rd != '0;
    end

    // Pending-write counters: simultaneous issue and retire cancel; retire at zero is ignored
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (issue_acc && bus.issue_rd == XADDR'(r) && wr_en_q && rd_addr_q == XADDR'(r)) ? cnt_q[r] :
                       (issue_acc && bus.issue_rd == XADDR'(r))                                    ? cnt_q[r] + 1'b1 :
                       (wr_en_q && rd_addr_q == XADDR'(r) && cnt_q[r] != '0)                      ? cnt_q[r] - 1'b1 :
                                                                                                      cnt_q[r];
        end
    end

    // FIFO storage needs no reset: entries are only read below the occupancy count
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[tail_q] <= entry_t'({bus.alu_rd, bus.alu_data});
    end

    // Pointers, occupancy, scoreboard and the registered write port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            head_q    <= head_q + PW'(pop);
            tail_q    <= tail_q + PW'(push);
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.alu_ready   = !full;
    assign bus.wr_en       = wr_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.rd_data     = rd_data_q;

`ifdef WB_FORWARD_EN
    // The last outstanding write is visible through the register file's write-through read
    assign bus.rs1_busy = cnt_q[bus.rs1_addr] != '0 &&
                          !(cnt_q[bus.rs1_addr] == CNT_W'(1) && wr_en_q && rd_addr_q == bus.rs1_addr);
    assign bus.rs2_busy = cnt_q[bus.rs2_addr] != '0 &&
                          !(cnt_q[bus.rs2_addr] == CNT_W'(1) && wr_en_q && rd_addr_q == bus.rs2_addr);
`else
    assign bus.rs1_busy = cnt_q[bus.rs1_addr] != '0;
    assign bus.rs2_busy = cnt_q[bus.rs2_addr] != '0;
`endif
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// tb_regfile_writeback_ctrl: directed scenarios plus randomized traffic against a queue/array reference model
module tb_regfile_writeback_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_if #(.XLEN(32), .XADDR(5)) bus ();

    regfile_writeback_ctrl #(.XLEN(32), .XADDR(5), .FIFO_DEPTH(4), .CNT_W(2)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [36:0] mq[$];
    int          mcnt[32];
    logic        m_wr   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    function automatic logic m_issue_ready(logic [4:0] rd);
        return rd == 0 || mcnt[rd] < 3 || (m_wr && m_addr == rd);
    endfunction

    function automatic logic m_busy(logic [4:0] rs);
        if (FWD) return mcnt[rs] != 0 && !(mcnt[rs] == 1 && m_wr && m_addr == rs);
        return mcnt[rs] != 0;
    endfunction

    task automatic model_step();
        logic [36:0] e;
        logic have, acc, inc;
        if (rst) begin
            mq.delete();
            foreach (mcnt[i]) mcnt[i] = 0;
            m_wr = 0; m_addr = 0; m_data = 0;
            return;
        end
        acc = bus.alu_valid && mq.size() < 4;
        inc = bus.issue_valid && m_issue_ready(bus.issue_rd) && bus.issue_rd != 0;
        if (!(inc && m_wr && m_addr == bus.issue_rd)) begin
            if (inc) mcnt[bus.issue_rd]++;
            if (m_wr && mcnt[m_addr] > 0) mcnt[m_addr]--;
        end
        have = 1'b1;
        if (bus.ld_valid) begin
            e = {bus.ld_rd, bus.ld_data};
            if (acc) mq.push_back({bus.alu_rd, bus.alu_data});
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (acc) mq.push_back({bus.alu_rd, bus.alu_data});
        end else if (acc) begin
            e = {bus.alu_rd, bus.alu_data};
        end else begin
            have = 1'b0;
            e = '0;
        end
        m_wr = have && e[36:32] != 0;
        if (m_wr) begin m_addr = e[36:32]; m_data = e[31:0]; end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.issue_valid = 0; bus.issue_rd = 0; bus.rs1_addr = 0; bus.rs2_addr = 0;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1; cycle(); cycle(); rst = 0;
        for (int i = 0; i < 3; i++) begin
            bus.issue_valid = 1; bus.issue_rd = 7;
            bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 32'(i);
            bus.ld_valid = 1; bus.ld_rd = 7; bus.ld_data = 32'h100 + 32'(i);
            cycle();
        end
        rst = 1; cycle(); cycle(); rst = 0;
        idle(); bus.rs1_addr = 7; bus.rs2_addr = 9; bus.issue_rd = 7; #1;
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", bus.wr_en); end
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %b want 1", bus.alu_ready); end
        checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b want 0", bus.rs1_busy); end
        checks++; if (bus.rs2_busy !== 1'b0) begin errors++; $display("FAIL reset_busy2 got %b want 0", bus.rs2_busy); end
        checks++; if (bus.rd_addr !== 5'd0 || bus.rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd got %0d/%h want 0/0", bus.rd_addr, bus.rd_data); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b want 1", bus.issue_ready); end
        cycle();
    endtask

    task automatic test_bypass();
        idle(); bus.issue_valid = 1; bus.issue_rd = 5; #1;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL bypass_issue got %b want 1", bus.issue_ready); end
        cycle();
        idle(); bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF; bus.rs1_addr = 5; #1;
        checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL bypass_busy_pending got %b want 1", bus.rs1_busy); end
        cycle();
        idle(); bus.rs1_addr = 5; #1;
        checks++; if (bus.wr_en !== 1'b1 || bus.rd_addr !== 5'd5 || bus.rd_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_write got %b/%0d/%h want 1/5/deadbeef", bus.wr_en, bus.rd_addr, bus.rd_data); end
        checks++; if (bus.rs1_busy !== !FWD) begin errors++; $display("FAIL bypass_busy_write got %b want %b", bus.rs1_busy, !FWD); end
        cycle();
        idle(); bus.rs1_addr = 5; #1;
        checks++; if (bus.wr_en !== 1'b0 || bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL bypass_after got %b/%b want 0/0", bus.wr_en, bus.rs1_busy); end
        cycle();
    endtask

    task automatic test_priority();
        idle(); bus.issue_valid = 1; bus.issue_rd = 3; cycle();
        idle(); bus.issue_valid = 1; bus.issue_rd = 4; cycle();
        idle(); bus.ld_valid = 1; bus.ld_rd = 3; bus.ld_data = 32'h3333_0003;
        bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 32'h4444_0004; bus.rs1_addr = 3; bus.rs2_addr = 4; #1;
        checks++; if (bus.alu_ready !== 1'b1 || bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1) begin
            errors++; $display("FAIL prio_pre got %b/%b/%b want 1/1/1", bus.alu_ready, bus.rs1_busy, bus.rs2_busy); end
        cycle();
        idle(); #1;
        checks++; if (bus.wr_en !== 1'b1 || bus.rd_addr !== 5'd3 || bus.rd_data !== 32'h3333_0003) begin
            errors++; $display("FAIL prio_load got %b/%0d/%h want 1/3/33330003", bus.wr_en, bus.rd_addr, bus.rd_data); end
        cycle();
        #1;
        checks++; if (bus.wr_en !== 1'b1 || bus.rd_addr !== 5'd4 || bus.rd_data !== 32'h4444_0004) begin
            errors++; $display("FAIL prio_alu got %b/%0d/%h want 1/4/44440004", bus.wr_en, bus.rd_addr, bus.rd_data); end
        cycle();
        bus.rs1_addr = 3; bus.rs2_addr = 4; #1;
        checks++; if (bus.wr_en !== 1'b0 || bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            errors++; $display("FAIL prio_after got %b/%b/%b want 0/0/0", bus.wr_en, bus.rs1_busy, bus.rs2_busy); end
        cycle();
    endtask

    task automatic test_full();
        for (int i = 0; i < 10; i++) begin
            idle(); bus.issue_valid = 1; bus.issue_rd = 5'(10 + i); cycle();
        end
        for (int k = 0; k < 6; k++) begin
            idle(); bus.ld_valid = 1; bus.ld_rd = 5'(10 + k); bus.ld_data = 32'h1000 + 32'(k);
            bus.alu_valid = k < 4; bus.alu_rd = 5'(16 + k); bus.alu_data = 32'h2000 + 32'(k); #1;
            checks++; if (bus.alu_ready !== (k < 4)) begin errors++; $display("FAIL full_ready[%0d] got %b want %b", k, bus.alu_ready, k < 4); end
            if (k > 0) begin
                checks++; if (bus.wr_en !== 1'b1 || bus.rd_addr !== 5'(9 + k) || bus.rd_data !== 32'h1000 + 32'(k - 1)) begin
                    errors++; $display("FAIL full_load[%0d] got %b/%0d/%h want 1/%0d/%h", k, bus.wr_en, bus.rd_addr, bus.rd_data, 9 + k, 32'h1000 + 32'(k - 1)); end
            end
            cycle();
        end
        idle(); #1;
        checks++; if (bus.alu_ready !== 1'b0 || bus.wr_en !== 1'b1 || bus.rd_addr !== 5'd15) begin
            errors++; $display("FAIL full_pop_ready got %b/%b/%0d want 0/1/15", bus.alu_ready, bus.wr_en, bus.rd_addr); end
        cycle();
        for (int j = 0; j < 4; j++) begin
            #1;
            checks++; if (bus.wr_en !== 1'b1 || bus.rd_addr !== 5'(16 + j) || bus.rd_data !== 32'h2000 + 32'(j) || bus.alu_ready !== 1'b1) begin
                errors++; $display("FAIL full_drain[%0d] got %b/%0d/%h/%b want 1/%0d/%h/1", j, bus.wr_en, bus.rd_addr, bus.rd_data, bus.alu_ready, 16 + j, 32'h2000 + 32'(j)); end
            cycle();
        end
        #1;
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", bus.wr_en); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            idle(); bus.issue_valid = 1; bus.issue_rd = 7; #1;
            checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL sat_issue[%0d] got %b want 1", i, bus.issue_ready); end
            cycle();
        end
        #1;
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL sat_full got %b want 0", bus.issue_ready); end
        cycle();
        bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 32'h77; #1;
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL sat_hold got %b want 0", bus.issue_ready); end
        cycle();
        bus.alu_valid = 0; #1;
        checks++; if (bus.wr_en !== 1'b1 || bus.issue_ready !== 1'b1) begin
            errors++; $display("FAIL sat_retire got %b/%b want 1/1", bus.wr_en, bus.issue_ready); end
        cycle();
        bus.issue_valid = 0; bus.rs1_addr = 7; #1;
        checks++; if (bus.issue_ready !== 1'b0 || bus.rs1_busy !== 1'b1) begin
            errors++; $display("FAIL sat_again got %b/%b want 0/1", bus.issue_ready, bus.rs1_busy); end
        for (int i = 0; i < 3; i++) begin
            idle(); bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 32'(i); cycle();
        end
        idle(); cycle();
        bus.rs1_addr = 7; bus.issue_rd = 7; #1;
        checks++; if (bus.rs1_busy !== 1'b0 || bus.issue_ready !== 1'b1) begin
            errors++; $display("FAIL sat_drained got %b/%b want 0/1", bus.rs1_busy, bus.issue_ready); end
        cycle();
    endtask

    task automatic test_x0_forward();
        idle(); bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hFFFF; bus.issue_valid = 1; bus.issue_rd = 0; #1;
        checks++; if (bus.issue_ready !== 1'b1 || bus.rs1_busy !== 1'b0) begin
            errors++; $display("FAIL x0_issue got %b/%b want 1/0", bus.issue_ready, bus.rs1_busy); end
        cycle();
        idle(); #1;
        checks++; if (bus.wr_en !== 1'b0 || bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_write got %b/%b want 0/0", bus.wr_en, bus.rs1_busy); end
        cycle();
        idle(); bus.issue_valid = 1; bus.issue_rd = 12; cycle();
        idle(); bus.alu_valid = 1; bus.alu_rd = 12; bus.alu_data = 32'hC; bus.rs1_addr = 12; bus.rs2_addr = 13; #1;
        checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL fwd_pending got %b want 1", bus.rs1_busy); end
        cycle();
        idle(); bus.rs1_addr = 12; #1;
        checks++; if (bus.wr_en !== 1'b1 || bus.rd_addr !== 5'd12 || bus.rs1_busy !== !FWD) begin
            errors++; $display("FAIL fwd_write got %b/%0d/%b want 1/12/%b", bus.wr_en, bus.rd_addr, bus.rs1_busy, !FWD); end
        cycle();
        bus.rs1_addr = 12; #1;
        checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL fwd_after got %b want 0", bus.rs1_busy); end
        bus.issue_valid = 1; bus.issue_rd = 13; cycle();
        cycle();
        idle(); bus.alu_valid = 1; bus.alu_rd = 13; bus.alu_data = 32'hD; cycle();
        idle(); bus.rs2_addr = 13; #1;
        checks++; if (bus.wr_en !== 1'b1 || bus.rs2_busy !== 1'b1) begin
            errors++; $display("FAIL fwd_cnt2 got %b/%b want 1/1", bus.wr_en, bus.rs2_busy); end
        bus.alu_valid = 1; bus.alu_rd = 13; bus.alu_data = 32'hE; cycle();
        idle(); cycle();
        bus.rs2_addr = 13; #1;
        checks++; if (bus.rs2_busy !== 1'b0) begin errors++; $display("FAIL fwd_cnt2_done got %b want 0", bus.rs2_busy); end
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = i == 300;
            bus.issue_valid = 1'($urandom_range(0, 1)); bus.issue_rd = 5'($urandom_range(0, 7));
            bus.alu_valid = ($urandom % 3) != 0; bus.alu_rd = 5'($urandom_range(0, 7)); bus.alu_data = $urandom;
            bus.ld_valid = ($urandom % 4) == 0; bus.ld_rd = 5'($urandom_range(0, 7)); bus.ld_data = $urandom;
            bus.rs1_addr = 5'($urandom_range(0, 7)); bus.rs2_addr = 5'($urandom_range(0, 7)); #1;
            checks++; if (bus.wr_en !== m_wr) begin errors++; $display("FAIL rnd_wr_en[%0d] got %b want %b", i, bus.wr_en, m_wr); end
            if (m_wr) begin
                checks++; if (bus.rd_addr !== m_addr || bus.rd_data !== m_data) begin
                    errors++; $display("FAIL rnd_rd[%0d] got %0d/%h want %0d/%h", i, bus.rd_addr, bus.rd_data, m_addr, m_data); end
            end
            checks++; if (bus.alu_ready !== (mq.size() < 4)) begin errors++; $display("FAIL rnd_alu_ready[%0d] got %b want %b", i, bus.alu_ready, mq.size() < 4); end
            checks++; if (bus.issue_ready !== m_issue_ready(bus.issue_rd)) begin
                errors++; $display("FAIL rnd_issue_ready[%0d] got %b want %b", i, bus.issue_ready, m_issue_ready(bus.issue_rd)); end
            checks++; if (bus.rs1_busy !== m_busy(bus.rs1_addr) || bus.rs2_busy !== m_busy(bus.rs2_addr)) begin
                errors++; $display("FAIL rnd_busy[%0d] got %b/%b want %b/%b", i, bus.rs1_busy, bus.rs2_busy, m_busy(bus.rs1_addr), m_busy(bus.rs2_addr)); end
            cycle();
        end
        rst = 0;
    endtask

    initial begin
        foreach (mcnt[i]) mcnt[i] = 0;
        test_reset();
        test_bypass();
        test_priority();
        test_full();
        test_saturation();
        test_x0_forward();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end
endmodule
